// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - operand FIFO and sequencer feeding an external MAC, capturing dot products
module mac_operand_feeder #(
   parameter int DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_a,
   input  logic [3:0] in_b,
   input  logic       in_last,
   output logic [3:0] operand_a,
   output logic [3:0] operand_b,
   output logic       mac_clear,
   input  logic [7:0] mac_result,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_data,
   output logic [3:0] out_count
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {CLEAR, ISSUE, DRAIN, CAPT, HOLD} state_t;

   state_t      state_q, state_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [8:0]  mem_q [DEPTH];
   logic [8:0]  head;
   logic        full, empty, push, pop;
   logic [3:0]  op_a_q, op_a_d, op_b_q, op_b_d;
   logic        mac_clear_q, mac_clear_d;
   logic        out_valid_q, out_valid_d;
   logic [7:0]  out_data_q, out_data_d;
   logic [3:0]  out_count_q, out_count_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        last_issued_q, last_issued_d;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];
   assign push  = in_valid && !full;
   assign pop   = (state_q == ISSUE) && !empty && !last_issued_q;

   assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
   assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};

   always_comb begin
      state_d       = state_q;
      op_a_d        = 4'd0;
      op_b_d        = 4'd0;
      out_valid_d   = out_valid_q;
      out_data_d    = out_data_q;
      out_count_d   = out_count_q;
      cnt_d         = cnt_q;
      last_issued_d = 1'b0;
      case (state_q)
         CLEAR: state_d = ISSUE;
         ISSUE: begin
            // The last pair's product reaches the accumulator one edge after issue,
            // so leave ISSUE one bubble later to keep the capture aligned.
            if (last_issued_q) begin
               state_d = DRAIN;
            end else if (pop) begin
               op_a_d        = head[7:4];
               op_b_d        = head[3:0];
               cnt_d         = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
               last_issued_d = head[8];
            end
         end
         DRAIN: state_d = CAPT;
         CAPT: begin
            out_data_d  = mac_result;
            out_count_d = cnt_q;
            out_valid_d = 1'b1;
            state_d     = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               cnt_d       = 4'd0;
               state_d     = CLEAR;
            end
         end
         default: state_d = CLEAR;
      endcase
      mac_clear_d = (state_d == CLEAR);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= CLEAR;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         op_a_q        <= 4'd0;
         op_b_q        <= 4'd0;
         mac_clear_q   <= 1'b1;
         out_valid_q   <= 1'b0;
         out_data_q    <= 8'd0;
         out_count_q   <= 4'd0;
         cnt_q         <= 4'd0;
         last_issued_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         op_a_q        <= op_a_d;
         op_b_q        <= op_b_d;
         mac_clear_q   <= mac_clear_d;
         out_valid_q   <= out_valid_d;
         out_data_q    <= out_data_d;
         out_count_q   <= out_count_d;
         cnt_q         <= cnt_d;
         last_issued_q <= last_issued_d;
      end
   end

   // Storage needs no reset; the pointers alone define occupancy.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_a, in_b};
   end

   assign in_ready  = !full;
   assign operand_a = op_a_q;
   assign operand_b = op_b_q;
   assign mac_clear = mac_clear_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;

endmodule
